hazard_ctrl_unit_p: RTL and testbench
=====================================

// Module: hazard_ctrl_unit_p
// PURPOSE
//  Next-generation MIPS pipeline hazard controller, sitting beside the ID stage. Detects load-use and
//  multi-cycle MUL/DIV hazards, stalls PC and IF/ID, injects ID/EX bubbles, and redirects/flushes on
//  taken branch/jump. Adds multi-cycle load stalls, a sequential stall FSM, and optional perf counters.
// PARAMETERS
//  REG_ADDR_W         5   register-number width
//  LOAD_STALL_CYCLES  1   bubbles per load-use hazard (1..15; >1 for slow data memory)
//  CNT_W              16  width of each perf counter
// PORTS
//  clk               in   1           pipeline clock
//  rst_n             in   1           async active-low reset
//  branch_Or_Jump    in   2           00 SEQ, 01 BR_NOT_TAKEN, 10 BR_TAKEN, 11 JUMP (resolved in ID)
//  ID_EX_MemRead     in   1           instruction in ID/EX is a load
//  ID_EX_Rt          in   REG_ADDR_W  load destination register
//  IF_ID_Rs          in   REG_ADDR_W  ID-stage source register 1
//  IF_ID_Rt          in   REG_ADDR_W  ID-stage source register 2
//  IF_ID_use_Rs      in   1           ID instruction actually reads Rs
//  IF_ID_use_Rt      in   1           ID instruction actually reads Rt
//  IF_ID_md_op       in   1           ID instruction is MULT/DIV/MFHI/MFLO
//  md_busy           in   1           MUL/DIV unit still computing
//  PC_Write          out  1           1 = PC may update
//  IF_ID_Write       out  1           1 = IF/ID may update
//  PC_Mux_select     out  2           00 PC+4, 01 branch target, 10 jump target
//  IF_ID_Mux_select  out  1           1 = flush IF/ID to NOP
//  ID_EX_Mux_select  out  1           1 = inject bubble into ID/EX
//  stall_state       out  2           FSM state: 00 RUN, 01 LD_STALL, 10 MD_STALL
//  stall_cycles      out  CNT_W       perf: total stalled cycles
//  flush_count       out  CNT_W       perf: total taken-branch/jump flushes
// BEHAVIOUR
//  - Async reset (rst_n low): state RUN, stall counter 0, perf counters 0; while rst_n low all
//    control outputs 0 (PC_Write=IF_ID_Write=0, selects 0). Reset mid-stall aborts the stall.
//  - Hazards: ld_haz = ID_EX_MemRead & ID_EX_Rt!=0 & ((use_Rs & Rt==Rs) | (use_Rt & Rt==IF_ID_Rt));
//    md_haz = IF_ID_md_op & md_busy. Same-cycle combinational outputs (no added latency).
//  - Stall outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Mux_select=1, PC_Mux_select=00,
//    IF_ID_Mux_select=0; branch_Or_Jump ignored while stalling (operands may be stale).
//  - RUN: ld_haz -> stall now; if LOAD_STALL_CYCLES>1 go LD_STALL, cnt=LOAD_STALL_CYCLES-1.
//    else md_haz -> stall now, go MD_STALL. else no stall: decode branch_Or_Jump.
//  - LD_STALL: stall every cycle; cnt decrements; cnt==1 -> RUN next edge. Total bubbles per hazard
//    = LOAD_STALL_CYCLES exactly. New hazard inputs ignored until back in RUN.
//  - MD_STALL: stall while md_haz; first cycle md_haz=0 outputs are the normal RUN decode, and the
//    FSM returns to RUN on that edge (no extra bubble).
//  - Control decode (no stall): SEQ/BR_NOT_TAKEN -> PC_Write=1, IF_ID_Write=1, all selects 0;
//    BR_TAKEN -> PC_Mux=01, IF_ID_Mux=1, ID_EX_Mux=1; JUMP -> PC_Mux=10, IF_ID_Mux=1, ID_EX_Mux=1.
//  - Priority: ld_haz > md_haz > control redirect. Encoding fully decoded; no undefined case.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cycles +1 on each rising clk edge where stall outputs are active;
//    flush_count +1 on each edge with BR_TAKEN/JUMP taken (not stalled). Both saturate at all-ones.
//  Not defined: counters not built; stall_cycles and flush_count tied to 0. Other behaviour identical.
// TESTING
//  1. LOAD_STALL_CYCLES=1; lw $t0 in ID/EX, add uses $t0 as Rs -> exactly 1 cycle PC_Write=0,
//     ID_EX_Mux=1; stall_state stays 00.
//  2. LOAD_STALL_CYCLES=3; same hazard -> 3 consecutive stall cycles, stall_state 01 for cycles 2-3,
//     then RUN; stall_cycles=3 with HAZARD_PERF_CNT_EN.
//  3. ID_EX_Rt=0 matching Rs, or match with use_Rs=0 -> no stall, PC_Write=1.
//  4. IF_ID_md_op=1, md_busy high 5 cycles -> 5 stall cycles, state 10, returns 00 when md_busy falls.
//  5. BR_TAKEN then JUMP, no hazard -> PC_Mux 01 then 10, IF_ID_Mux=ID_EX_Mux=1; flush_count=2;
//     BR_TAKEN coincident with ld_haz -> stall, PC_Mux=00, flush_count unchanged.
//  6. Drop rst_n during LD_STALL (cnt=2) -> immediately outputs 0, state 00, counters 0;
//     after release no residual stall.

Source files
------------

// File: rtl/hazard_ctrl_unit_p.sv
// hazard_ctrl_unit_p: MIPS ID-stage hazard controller (load-use / MUL-DIV stalls, branch/jump redirect)
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   branch_Or_Jump                    00 SEQ, 01 BR_NOT_TAKEN, 10 BR_TAKEN, 11 JUMP
//   ID_EX_MemRead, ID_EX_Rt           load in ID/EX and its destination
//   IF_ID_Rs/Rt, IF_ID_use_Rs/Rt      ID-stage sources and whether they are read
//   IF_ID_md_op, md_busy              MUL/DIV access in ID, MUL/DIV unit busy
//   PC_Write, IF_ID_Write             pipeline register enables
//   PC_Mux_select                     00 PC+4, 01 branch target, 10 jump target
//   IF_ID_Mux_select, ID_EX_Mux_select flush IF/ID, bubble ID/EX
//   stall_state                       00 RUN, 01 LD_STALL, 10 MD_STALL
//   stall_cycles, flush_count         perf counters, built only with HAZARD_PERF_CNT_EN
module hazard_ctrl_unit_p #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            branch_Or_Jump,
    input  logic                  ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
    input  logic                  IF_ID_use_Rs,
    input  logic                  IF_ID_use_Rt,
    input  logic                  IF_ID_md_op,
    input  logic                  md_busy,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic [1:0]            PC_Mux_select,
    output logic                  IF_ID_Mux_select,
    output logic                  ID_EX_Mux_select,
    output logic [1:0]            stall_state,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);
    typedef enum logic [1:0] {RUN = 2'b00, LD_STALL = 2'b01, MD_STALL = 2'b10} state_t;
    localparam logic [3:0] LD_INIT = 4'(LOAD_STALL_CYCLES - 1);
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ld_haz, md_haz, stall, taken;
    assign ld_haz = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                    ((IF_ID_use_Rs && ID_EX_Rt == IF_ID_Rs) || (IF_ID_use_Rt && ID_EX_Rt == IF_ID_Rt));
    assign md_haz = IF_ID_md_op && md_busy;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            RUN: begin
                if (ld_haz) begin
                    stall = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LD_STALL;
                        cnt_d   = LD_INIT;
                    end
                end else if (md_haz) begin
                    stall   = 1'b1;
                    state_d = MD_STALL;
                end
            end
            LD_STALL: begin
                stall   = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? RUN : LD_STALL;
            end
            MD_STALL: begin
                stall   = md_haz;
                state_d = md_haz ? MD_STALL : RUN;
            end
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // Redirect only when not stalling: operands of a stalled branch may be stale.
    assign taken            = !stall && branch_Or_Jump[1];
    assign PC_Write         = rst_n && !stall;
    assign IF_ID_Write      = rst_n && !stall;
    assign PC_Mux_select    = (rst_n && taken) ? ((branch_Or_Jump == 2'b11) ? 2'b10 : 2'b01) : 2'b00;
    assign IF_ID_Mux_select = rst_n && taken;
    assign ID_EX_Mux_select = rst_n && (stall || taken);
    assign stall_state      = rst_n ? state_q : 2'b00;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    always_comb begin
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (taken && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit_p.sv
// tb_hazard_ctrl_unit_p: scoreboard bench driving an L=1 and an L=3 controller from shared inputs
module tb_hazard_ctrl_unit_p;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] bj = 2'b00;
    logic       mr = 1'b0, urs = 1'b0, urt = 1'b0, mdop = 1'b0, busy = 1'b0;
    logic [4:0] ert = '0, rs = '0, rt = '0;
    logic       pcw1, ifw1, ifm1, idex1, pcw3, ifw3, ifm3, idex3;
    logic [1:0] pcm1, st1, pcm3, st3;
    logic [15:0] sc1, fc1, sc3, fc3;
    int n_vec = 0, n_bad = 0;
    always #5 clk = ~clk;
    hazard_ctrl_unit_p #(.LOAD_STALL_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .branch_Or_Jump(bj), .ID_EX_MemRead(mr), .ID_EX_Rt(ert),
        .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_use_Rs(urs), .IF_ID_use_Rt(urt),
        .IF_ID_md_op(mdop), .md_busy(busy), .PC_Write(pcw1), .IF_ID_Write(ifw1),
        .PC_Mux_select(pcm1), .IF_ID_Mux_select(ifm1), .ID_EX_Mux_select(idex1),
        .stall_state(st1), .stall_cycles(sc1), .flush_count(fc1));
    hazard_ctrl_unit_p #(.LOAD_STALL_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .branch_Or_Jump(bj), .ID_EX_MemRead(mr), .ID_EX_Rt(ert),
        .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_use_Rs(urs), .IF_ID_use_Rt(urt),
        .IF_ID_md_op(mdop), .md_busy(busy), .PC_Write(pcw3), .IF_ID_Write(ifw3),
        .PC_Mux_select(pcm3), .IF_ID_Mux_select(ifm3), .ID_EX_Mux_select(idex3),
        .stall_state(st3), .stall_cycles(sc3), .flush_count(fc3));
    typedef struct {string tag; logic [7:0] e1; logic [7:0] e3;} exp_t;
    exp_t sb[$];
    int  m1_left = 0, m3_left = 0, m1_sc = 0, m1_fc = 0, m3_sc = 0, m3_fc = 0;
    bit  m1_md = 0, m3_md = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Outputs packed as {PC_Write, IF_ID_Write, PC_Mux[1:0], IF_ID_Mux, ID_EX_Mux, stall_state[1:0]}
    task automatic model(input int L, inout int left, inout bit mdst, inout int sc, inout int fc,
                         output logic [7:0] e);
        logic ld, md;
        logic [5:0] dec;
        ld  = mr && ert != 0 && ((urs && ert == rs) || (urt && ert == rt));
        md  = mdop && busy;
        dec = (bj == 2'b10) ? 6'b110111 : (bj == 2'b11) ? 6'b111011 : 6'b110000;
        if (!rst_n) begin
            e = 8'h00; left = 0; mdst = 0; sc = 0; fc = 0;
        end else if (left > 0) begin
            e = {6'b000001, 2'b01}; left--; sc++;
        end else if (mdst) begin
            if (md) begin
                e = {6'b000001, 2'b10}; sc++;
            end else begin
                e = {dec, 2'b10}; mdst = 0; fc += bj[1];
            end
        end else if (ld) begin
            e = {6'b000001, 2'b00}; left = L - 1; sc++;
        end else if (md) begin
            e = {6'b000001, 2'b00}; mdst = 1; sc++;
        end else begin
            e = {dec, 2'b00}; fc += bj[1];
        end
    endtask
    task automatic step(input string tag, input logic r, input logic [1:0] b, input logic m,
                        input logic [4:0] et, input logic [4:0] s, input logic [4:0] t,
                        input logic us, input logic ut, input logic mo, input logic bz);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r; bj = b; mr = m; ert = et; rs = s; rt = t; urs = us; urt = ut; mdop = mo; busy = bz;
        x.tag = tag;
        model(1, m1_left, m1_md, m1_sc, m1_fc, x.e1);
        model(3, m3_left, m3_md, m3_sc, m3_fc, x.e3);
        sb.push_back(x);
    endtask
    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check({x.tag, "/L1"}, {pcw1, ifw1, pcm1, ifm1, idex1, st1}, x.e1);
            check({x.tag, "/L3"}, {pcw3, ifw3, pcm3, ifm3, idex3, st3}, x.e3);
        end
    end
    initial begin
        for (int i = 0; i < 2; i++) step("reset", 0, 2'b11, 1, 8, 8, 8, 1, 1, 1, 1);
        idle("idle", 2);
        step("ld_rs", 1, 2'b00, 1, 8, 8, 3, 1, 1, 0, 0);
        idle("ld_after", 4);
        step("ld_rt", 1, 2'b00, 1, 9, 2, 9, 0, 1, 0, 0);
        idle("ld_after2", 4);
        step("rt_zero", 1, 2'b00, 1, 0, 0, 0, 1, 1, 0, 0);
        step("no_use", 1, 2'b00, 1, 8, 8, 8, 0, 0, 0, 0);
        step("not_ld", 1, 2'b00, 0, 8, 8, 8, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("md_busy", 1, 2'b10, 0, 0, 0, 0, 0, 0, 1, 1);
        step("md_done", 1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        idle("md_after", 1);
        step("md_idle_unit", 1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        step("md_exit_br", 1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 1);
        step("md_exit_br2", 1, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0);
        step("br_taken", 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        step("jump", 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        step("br_nt", 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        step("br_vs_ld", 1, 2'b10, 1, 5, 5, 0, 1, 0, 0, 0);
        step("jump_in_ldst", 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        step("br_in_ldst", 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        step("ld_vs_md", 1, 2'b00, 1, 4, 4, 0, 1, 0, 1, 1);
        idle("ld_vs_md_after", 3);
        step("ld_pre_rst", 1, 2'b00, 1, 7, 7, 0, 1, 0, 0, 0);
        step("rst_mid_stall", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("post_rst", 3);
        for (int i = 0; i < 80; i++)
            step("rand", 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        idle("tail", 3);
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cycles_L1", 32'(sc1), 32'(m1_sc));
        check("flush_count_L1", 32'(fc1), 32'(m1_fc));
        check("stall_cycles_L3", 32'(sc3), 32'(m3_sc));
        check("flush_count_L3", 32'(fc3), 32'(m3_fc));
`else
        check("stall_cycles_L1", 32'(sc1), 0);
        check("flush_count_L1", 32'(fc1), 0);
        check("stall_cycles_L3", 32'(sc3), 0);
        check("flush_count_L3", 32'(fc3), 0);
`endif
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
